// File: rtl/byte_lane_dly_seq.sv
// Streams the 19 programmed taps of a 32x8 shadow table into a DDR3 byte lane, then strobes set.
// Latency: ld_delay on E1..E19 after start at E0, set at E(20+SET_GAP), done at E(21+SET_GAP).
// Backpressure: none; start while busy is ignored and writes while busy are dropped (flagged on wr_err).
module byte_lane_dly_seq #(
  parameter int SET_GAP = 2
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       wr_err,
  output logic [7:0] dly_data,
  output logic [4:0] dly_addr,
  output logic       ld_delay,
  output logic       set
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_SET, S_DONE} state_t;

  localparam logic [3:0] GAP_LAST = 4'(SET_GAP - 1);

  state_t     state_q, state_d;
  logic [4:0] k_q, k_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tbl_q [32];
  logic [4:0] lane_addr;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ld_q, ld_d;
  logic       set_q, set_d;
  logic       err_q;
  logic [7:0] data_q, data_d;
  logic [4:0] addr_q, addr_d;

  // Indices 0..9 map to output delays, 10..18 skip the hole to the input delays at 16..24.
  assign lane_addr = (k_q < 5'd10) ? k_q : k_q + 5'd6;

  // State, sequence index and gap counter registers.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: walk the 19 entries, wait out the gap, then set and done.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        k_d   = k_q + 5'd1;
        cnt_d = '0;
        if (k_q == 5'd18) begin
          state_d = (SET_GAP == 0) ? S_SET : S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == GAP_LAST) begin
          state_d = S_SET;
        end
      end
      S_SET:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state; registered below so the lane sees clean strobes.
  always_comb begin
    busy_d = (state_q != S_IDLE);
    ld_d   = (state_q == S_LOAD);
    set_d  = (state_q == S_SET);
    done_d = (state_q == S_DONE);
    addr_d = ld_d ? lane_addr : 5'd0;
    data_d = ld_d ? tbl_q[lane_addr] : 8'd0;
  end

  // Output registers; async reset drops everything to zero immediately.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ld_q   <= 1'b0;
      set_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      ld_q   <= ld_d;
      set_q  <= set_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Sticky dropped-write flag, cleared only by an accepted start.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      err_q <= 1'b0;
    end else if (state_q != S_IDLE && wr_en) begin
      err_q <= 1'b1;
    end
  end

  // Shadow table: writes land only while idle, so a write alongside start is streamed.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (state_q == S_IDLE && wr_en) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_err   = err_q;
  assign dly_data = data_q;
  assign dly_addr = addr_q;
  assign ld_delay = ld_q;
  assign set      = set_q;

endmodule

// File: tb/tb_byte_lane_dly_seq.sv
module tb_byte_lane_dly_seq;

  logic       clk_div = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;

  // Instance a: default SET_GAP=2; instance b: SET_GAP=0. Both share stimulus.
  logic       a_busy, a_done, a_err, a_ld, a_set;
  logic [7:0] a_data;
  logic [4:0] a_addr;
  logic       b_busy, b_done, b_err, b_ld, b_set;
  logic [7:0] b_data;
  logic [4:0] b_addr;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_tbl [32];
  bit         m_err;
  int         lane_list [19];

  always #5 clk_div = ~clk_div;

  byte_lane_dly_seq #(.SET_GAP(2)) u_a (
    .clk_div(clk_div), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(a_busy), .done(a_done), .wr_err(a_err), .dly_data(a_data),
    .dly_addr(a_addr), .ld_delay(a_ld), .set(a_set)
  );

  byte_lane_dly_seq #(.SET_GAP(0)) u_b (
    .clk_div(clk_div), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(b_busy), .done(b_done), .wr_err(b_err), .dly_data(b_data),
    .dly_addr(b_addr), .ld_delay(b_ld), .set(b_set)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_div);
    #1;
  endtask

  task automatic host_wr(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    m_tbl[a] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_tbl[i] = 8'h00;
    m_err = 1'b0;
  endtask

  // Expected lane behaviour n cycles after the start edge for a lane with gap g.
  task automatic chk_inst(input string who, input int n, input int g,
                          input logic busy_o, input logic done_o, input logic err_o,
                          input logic [7:0] data_o, input logic [4:0] addr_o,
                          input logic ld_o, input logic set_o);
    bit         ld_e;
    logic [4:0] a_e;
    logic [7:0] d_e;
    ld_e = (n >= 1 && n <= 19);
    a_e  = ld_e ? 5'(lane_list[n-1]) : 5'd0;
    d_e  = ld_e ? m_tbl[a_e] : 8'd0;
    chk($sformatf("%s E%0d ld", who, n), 32'(ld_o), 32'(ld_e));
    chk($sformatf("%s E%0d addr", who, n), 32'(addr_o), 32'(a_e));
    chk($sformatf("%s E%0d data", who, n), 32'(data_o), 32'(d_e));
    chk($sformatf("%s E%0d set", who, n), 32'(set_o), 32'(n == 20 + g));
    chk($sformatf("%s E%0d done", who, n), 32'(done_o), 32'(n == 21 + g));
    chk($sformatf("%s E%0d busy", who, n), 32'(busy_o), 32'(n >= 1 && n <= 21 + g));
    chk($sformatf("%s E%0d wr_err", who, n), 32'(err_o), 32'(m_err));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " a outs"}, {a_busy, a_done, a_err, a_ld, a_set, a_data, a_addr}, 0);
    chk({tag, " b outs"}, {b_busy, b_done, b_err, b_ld, b_set, b_data, b_addr}, 0);
  endtask

  // One full sequence. again_n/wr_n/rst_n select the cycle of an extra start,
  // a dropped write to entry 3, or a mid-sequence reset (0 = none).
  task automatic run_seq(input int again_n, input int wr_n, input int rst_n,
                         input bit same_wr, input logic [7:0] same_d);
    int a_lds = 0, a_sets = 0, b_lds = 0, b_sets = 0;
    start = 1'b1;
    if (same_wr) begin
      wr_en = 1'b1; wr_addr = 5'd24; wr_data = same_d;
    end
    tick();
    if (same_wr) m_tbl[24] = same_d;
    m_err = 1'b0;
    start = 1'b0; wr_en = 1'b0;
    chk("E0 a busy", 32'(a_busy), 0);
    chk("E0 b busy", 32'(b_busy), 0);
    for (int n = 1; n <= 25; n++) begin
      if (n == rst_n) begin
        #2 rst = 1'b1;
        #1 chk_zero("async rst");
        tick(); tick();
        chk_zero("held rst");
        rst = 1'b0;
        model_reset();
        tick();
        chk_zero("post rst");
        return;
      end
      start = (n == again_n);
      wr_en = (n == wr_n); wr_addr = 5'd3; wr_data = 8'($urandom);
      tick();
      if (n == wr_n) m_err = 1'b1;
      start = 1'b0; wr_en = 1'b0;
      chk_inst("a", n, 2, a_busy, a_done, a_err, a_data, a_addr, a_ld, a_set);
      chk_inst("b", n, 0, b_busy, b_done, b_err, b_data, b_addr, b_ld, b_set);
      a_lds += int'(a_ld); a_sets += int'(a_set);
      b_lds += int'(b_ld); b_sets += int'(b_set);
    end
    chk("a ld count", 32'(a_lds), 19);
    chk("a set count", 32'(a_sets), 1);
    chk("b ld count", 32'(b_lds), 19);
    chk("b set count", 32'(b_sets), 1);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) lane_list[i] = i;
    for (int i = 0; i < 9; i++) lane_list[10 + i] = 16 + i;
    model_reset();

    #1 rst = 1'b1;
    #12 chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("idle after reset");

    // Ramp table, full sequence.
    for (int i = 0; i < 32; i++) host_wr(5'(i), 8'(8'h40 + i));
    run_seq(0, 0, 0, 1'b0, 8'h00);

    // Restart pulse at E5 ignored, write to entry 3 at E10 dropped.
    run_seq(5, 10, 0, 1'b0, 8'h00);

    // Next start clears wr_err; write alongside start is streamed at E19.
    run_seq(0, 0, 0, 1'b1, 8'hAA);

    // Reset at E12 abandons the sequence and clears the table.
    run_seq(0, 0, 12, 1'b0, 8'h00);
    run_seq(0, 0, 0, 1'b0, 8'h00);

    // Unstreamed entries must never reach the lane.
    host_wr(5'd12, 8'hFF);
    host_wr(5'd30, 8'hFF);
    run_seq(0, 0, 0, 1'b0, 8'h00);

    // Randomized table contents and in-flight disturbances.
    for (int it = 0; it < 8; it++) begin
      int nw;
      nw = $urandom_range(1, 12);
      for (int w = 0; w < nw; w++) host_wr(5'($urandom), 8'($urandom));
      run_seq($urandom_range(0, 20), $urandom_range(0, 20), 0,
              1'($urandom), 8'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
